uart_word_tx: RTL and testbench
===============================

# uart_word_tx

Word-oriented UART transmitter for the controller's host link: accepts `BUS_WIDTH`-bit words on a read/write-style request/response handshake, buffers them in a small FIFO, and serializes each word as `WORD_SIZE_BY` 8N1 byte frames on `tx`. It is the send direction of the host protocol, returning command results and memory dumps to the host. It sits between the command interpreter's `uart_write`/`uart_write_data`/`uart_write_response` signals and the board TX pin.

## Interface
- `CLK_FREQ`, 25000000: system clock frequency in Hz.
- `BIT_RATE`, 9600: serial bit rate in bit/s.
- `PAYLOAD_BITS`, 8: data bits per frame.
- `WORD_SIZE_BY`, 4: bytes per word.
- `BUS_WIDTH`, 32: word width; must equal `PAYLOAD_BITS*WORD_SIZE_BY`.
- `BUFFER_SIZE`, 8: FIFO depth in words; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  **synchronous, active-low** reset.
- `write`  in  1  write request, level; sampled on every edge.
- `write_data`  in  `BUS_WIDTH`  word to send.
- `write_response`  out  1  one-cycle pulse: the word was accepted.
- `tx`  out  1  serial output; idles high.
- `uart_tx_full`  out  1  FIFO full.
- `uart_tx_empty`  out  1  FIFO empty and serializer idle.

## Operation
- `CLKS_PER_BIT = CLK_FREQ / BIT_RATE`, integer division with truncation. The bit counter is wide enough for this value.
- **Accept.** On an edge where `write`=1 and the FIFO is not full:
  - `write_data` is pushed.
  - `write_response`=1 for the following cycle only.
  - `write` held high pushes one word per cycle while space remains.
- **Full.** `write` while full is ignored and produces no response.
  - Fullness is evaluated before the same-cycle pop, so a write on a full FIFO is dropped even if a pop occurs on that edge.
- **Byte order.** Most-significant byte first, bits LSB-first within each byte.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift word, set byte index to 0, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `PAYLOAD_BITS` bits, each held for `CLKS_PER_BIT` cycles, then go to PARITY or STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles.
    - If byte index < `WORD_SIZE_BY-1`: increment the index and go to START.
    - Else if the FIFO is non-empty: pop and go to START directly, with no idle gap.
    - Else: go to IDLE.
- `uart_tx_empty` = FIFO empty and state is IDLE.
- **Reset (mid-frame or otherwise):**
  - `tx`=1 from the next edge.
  - FIFO cleared, FSM in IDLE, counters zero.
  - Partial word discarded and never resumed.

## Timing
- Reset values: `tx`=1, `write_response`=0, `uart_tx_full`=0, `uart_tx_empty`=1.
- Latency, starting from an idle, empty block:
  - write accepted at edge E0.
  - `write_response` is high between E0 and E1.
  - FSM pops at E1.
  - `tx` goes low after E2, i.e. 2 cycles from acceptance.
- Frame length: `(PAYLOAD_BITS+2)*CLKS_PER_BIT` cycles, plus `CLKS_PER_BIT` with parity.
- Word length: `WORD_SIZE_BY` consecutive frames with no gaps.
- `uart_tx_full` and `uart_tx_empty` are registered and valid the cycle after the push or pop that changes them.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is inserted after DATA, carrying even parity (XOR of the data bits), held for `CLKS_PER_BIT` cycles. Frame is 8E1.
- `UART_TX_PARITY_EN` undefined: no PARITY state. Frame is 8N1.

## Structure
- Package `uart_tx_pkg` holds:
  - the state enum;
  - a constant function computing `CLKS_PER_BIT` and its counter width;
  - a `$clog2`-based index-width helper.
- Sub-module `word_fifo`:
  - synchronous, parameterised width and depth;
  - push/pop inputs, full/empty outputs;
  - pointers carry one extra bit for full/empty discrimination.
- The top level contains the FSM, bit/byte counters and shift register.

## Test plan
All scenarios use `CLK_FREQ`=1000 and `BIT_RATE`=100, so `CLKS_PER_BIT`=10.
- **Single word.** Write 0xA5C30F81.
  - Bytes on `tx` in order: 0xA5, 0xC3, 0x0F, 0x81.
  - First frame: 0, then 1,0,1,0,0,1,0,1, then 1.
  - Start bit goes low 2 cycles after acceptance.
  - 400 cycles total; `uart_tx_empty` returns to 1 afterwards.
- **Back-to-back.** Hold `write` high for 3 words.
  - Three consecutive `write_response` pulses.
  - 1200 continuous cycles of frames with no idle high gap between words.
- **Full.** Fill 8 words while transmission is stalled at word 0.
  - `uart_tx_full`=1 after accepting the 8th push-capable write.
  - A 9th write yields no `write_response` and that word never appears on `tx`.
- **Full plus pop.** Issue a write in the same cycle the FSM pops from a full FIFO.
  - The write is dropped; no response.
- **Reset mid-frame.** Drive `reset`=0 during DATA of byte 2.
  - `tx`=1 on the next cycle and `uart_tx_empty`=1.
  - After release, a new write of 0x00000001 transmits cleanly.
- **Parity.** With `UART_TX_PARITY_EN` defined, write 0x07000000.
  - First frame carries parity bit 1; the three 0x00 frames carry 0.
  - Word length is 440 cycles.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and elaboration helpers for the word-oriented UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state (8E1 frames); undefined gives 8N1.
package uart_tx_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
`endif

  function automatic int calc_clks_per_bit(input int clk_freq, input int bit_rate);
    return clk_freq / bit_rate;
  endfunction

  // Wide enough to hold the clocks-per-bit value itself.
  function automatic int calc_cnt_width(input int clks_per_bit);
    return (clks_per_bit < 1) ? 1 : $clog2(clks_per_bit + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Write-side handshake between the command interpreter and uart_word_tx.
interface uart_word_tx_if #(
  parameter int BUS_WIDTH = 32
);
  // write is a level request sampled on every rising edge; a word is taken on
  // an edge where write=1 and the FIFO is not full, and write_response pulses
  // for exactly the following cycle. A write while full is silently dropped.
  logic                 write;
  logic [BUS_WIDTH-1:0] write_data;
  logic                 write_response;

  modport master (output write, output write_data, input  write_response);
  modport slave  (input  write, input  write_data, output write_response);
endinterface

// File: rtl/word_fifo.sv
// Synchronous FIFO with first-word fall-through read; pointers carry an
// extra wrap bit so full and empty are distinguished without a counter.
module word_fifo
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = idx_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}});
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/uart_word_tx.sv
// Word-oriented UART transmitter: FIFO-buffered words sent MSB byte first as
// back-to-back frames. Define UART_TX_PARITY_EN for an even-parity bit (8E1).
module uart_word_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ     = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int WORD_SIZE_BY = 4,
  parameter int BUS_WIDTH    = 32,
  parameter int BUFFER_SIZE  = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_word_tx_if.slave  bus,
  output logic           tx,
  output logic           uart_tx_full,
  output logic           uart_tx_empty,
  output state_t         dbg_state
);
  localparam int CPB    = calc_clks_per_bit(CLK_FREQ, BIT_RATE);
  localparam int CNT_W  = calc_cnt_width(CPB);
  localparam int BIT_W  = idx_width(PAYLOAD_BITS);
  localparam int BYTE_W = idx_width(WORD_SIZE_BY);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(WORD_SIZE_BY - 1);

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_clk_cnt, w_clk_cnt_nxt;
  logic [BIT_W-1:0]          r_bit_idx, w_bit_idx_nxt;
  logic [BYTE_W-1:0]         r_byte_idx, w_byte_idx_nxt;
  logic [BUS_WIDTH-1:0]      r_shift, w_shift_nxt;
  logic                      r_tx, w_tx_nxt;
  logic                      r_resp;
  logic                      w_push, w_pop, w_bit_end;
  logic                      w_fifo_full, w_fifo_empty;
  logic [BUS_WIDTH-1:0]      w_fifo_data;
  logic [PAYLOAD_BITS-1:0]   w_cur_byte;

  // Fullness is taken before any same-edge pop, so a write on a full FIFO drops.
  assign w_push     = bus.write && !w_fifo_full;
  assign w_bit_end  = (r_clk_cnt == CNT_LAST);
  assign w_cur_byte = r_shift[BUS_WIDTH-1 -: PAYLOAD_BITS];

  word_fifo #(.WIDTH(BUS_WIDTH), .DEPTH(BUFFER_SIZE)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bus.write_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_clk_cnt_nxt  = w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_shift_nxt    = r_shift;
    w_pop          = 1'b0;
    w_tx_nxt       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_clk_cnt_nxt = '0;
        if (!w_fifo_empty) begin
          w_pop          = 1'b1;
          w_shift_nxt    = w_fifo_data;
          w_byte_idx_nxt = '0;
          w_state_nxt    = ST_START;
        end
      end
      ST_START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_end) begin
          w_bit_idx_nxt = '0;
          w_state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        w_tx_nxt = w_cur_byte[r_bit_idx];
        if (w_bit_end) begin
          if (r_bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        w_tx_nxt = ^w_cur_byte;
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_byte_idx != BYTE_LAST) begin
            w_byte_idx_nxt = r_byte_idx + BYTE_W'(1);
            w_shift_nxt    = r_shift << PAYLOAD_BITS;
            w_state_nxt    = ST_START;
          end else if (!w_fifo_empty) begin
            // Chain straight into the next word with no idle gap.
            w_pop          = 1'b1;
            w_shift_nxt    = w_fifo_data;
            w_byte_idx_nxt = '0;
            w_state_nxt    = ST_START;
          end else begin
            w_state_nxt    = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // tx is registered, so the line trails the state by one cycle throughout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_resp     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_resp     <= w_push;
    end
  end

  assign bus.write_response = r_resp;
  assign tx                 = r_tx;
  assign uart_tx_full       = w_fifo_full;
  assign uart_tx_empty      = w_fifo_empty && (r_state == ST_IDLE);
  assign dbg_state          = r_state;
endmodule

// File: tb/tb_uart_word_tx.sv
// Directed/random bench for uart_word_tx: a serial monitor decodes tx frames
// and a byte scoreboard built from written words checks order, framing and gaps.
module tb_uart_word_tx;
  import uart_tx_pkg::*;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif
  localparam int WORD_CYC = 4 * FRAME;

  logic   clk;
  logic   reset;
  logic   tx;
  logic   uart_tx_full;
  logic   uart_tx_empty;
  state_t dbg_state;

  uart_word_tx_if #(.BUS_WIDTH(32)) bus_if ();

  uart_word_tx #(
    .CLK_FREQ(1000), .BIT_RATE(100), .PAYLOAD_BITS(8),
    .WORD_SIZE_BY(4), .BUS_WIDTH(32), .BUFFER_SIZE(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus_if),
    .tx            (tx),
    .uart_tx_full  (uart_tx_full),
    .uart_tx_empty (uart_tx_empty),
    .dbg_state     (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_epoch = 0;
  always @(negedge clk) if (reset === 1'b0) rst_epoch = rst_epoch + 1;

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       rxp_q[$];
  int         rxt_q[$];
  int         stop_err = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  // serial monitor: samples each bit at its middle, drops frames cut by reset
  logic [7:0] mon_b;
  logic       mon_p;
  logic       mon_s;
  int         mon_ep;
  int         mon_t0;
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        mon_ep = rst_epoch;
        mon_t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        mon_p = tx;
`else
        mon_p = ^mon_b;
`endif
        repeat (CPB) @(negedge clk);
        mon_s = tx;
        if (mon_ep == rst_epoch) begin
          rx_q.push_back(mon_b);
          rxp_q.push_back(mon_p);
          rxt_q.push_back(mon_t0);
          if (mon_s !== 1'b1) stop_err++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: a word becomes its bytes, most significant first
  task automatic model_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("rx_count_reached", 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (uart_tx_empty !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", 32'(uart_tx_empty), 32'd1);
  endtask

  task automatic check_bytes(input string tag);
    int prev = -1;
    int bad_gap = 0;
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() == 0) begin
        chk(tag, 32'hxxxxxxxx, 32'(e));
      end else begin
        chk(tag, 32'(rx_q.pop_front()), 32'(e));
        chk({tag, "_parity"}, 32'(rxp_q.pop_front()), 32'(^e));
        if (prev >= 0 && rxt_q[0] - prev != FRAME) bad_gap++;
        prev = rxt_q.pop_front();
      end
    end
    chk({tag, "_gaps"}, 32'(bad_gap), 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w);
    bus_if.write      = 1'b1;
    bus_if.write_data = w;
    @(negedge clk);
    chk("send_resp", 32'(bus_if.write_response), 32'd1);
    bus_if.write = 1'b0;
    model_word(w);
  endtask

  logic [31:0] words[10];
  logic [31:0] w_rst;
  int          occ;
  int          c0;
  int          k;
  logic        acc;

  initial begin
    bus_if.write      = 1'b0;
    bus_if.write_data = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_resp", 32'(bus_if.write_response), 32'd0);
    chk("rst_full", 32'(uart_tx_full), 32'd0);
    chk("rst_empty", 32'(uart_tx_empty), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single word: latency, bit pattern and word length
    bus_if.write      = 1'b1;
    bus_if.write_data = 32'hA5C30F81;
    @(negedge clk);
    bus_if.write = 1'b0;
    model_word(32'hA5C30F81);
    chk("single_resp", 32'(bus_if.write_response), 32'd1);
    chk("single_tx_e0", 32'(tx), 32'd1);
    chk("single_empty_e0", 32'(uart_tx_empty), 32'd0);
    @(negedge clk);
    chk("single_resp_e1", 32'(bus_if.write_response), 32'd0);
    chk("single_tx_e1", 32'(tx), 32'd1);
    @(negedge clk);
    chk("single_start_low", 32'(tx), 32'd0);
    repeat (WORD_CYC - 2) @(negedge clk);
    chk("single_empty_last", 32'(uart_tx_empty), 32'd0);
    @(negedge clk);
    chk("single_empty_after", 32'(uart_tx_empty), 32'd1);
    wait_rx(4, 200);
    check_bytes("single_byte");
    repeat (20) @(negedge clk);

    // back-to-back: write held high for three random words
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    bus_if.write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_if.write_data = words[i];
      @(negedge clk);
      chk("b2b_resp", 32'(bus_if.write_response), 32'd1);
      model_word(words[i]);
    end
    bus_if.write = 1'b0;
    @(negedge clk);
    chk("b2b_resp_end", 32'(bus_if.write_response), 32'd0);
    wait_rx(12, 3 * WORD_CYC + 200);
    check_bytes("b2b_byte");
    wait_idle(200);
    repeat (20) @(negedge clk);

    // full: ten writes back-to-back while word 0 is on the line
    for (int i = 0; i < 10; i++) words[i] = $urandom;
    occ = 0;
    for (int i = 0; i < 10; i++) begin
      bus_if.write      = 1'b1;
      bus_if.write_data = words[i];
      @(negedge clk);
      if (i == 0) c0 = cyc;
      acc = (occ < 8);
      occ = occ + (acc ? 1 : 0) - ((i == 1) ? 1 : 0);
      chk("full_resp", 32'(bus_if.write_response), 32'(acc));
      chk("full_flag", 32'(uart_tx_full), 32'(occ == 8));
      if (acc) model_word(words[i]);
    end
    bus_if.write = 1'b0;

    // write on the very edge the FSM pops from the full FIFO
    k = 0;
    while (cyc != c0 + WORD_CYC && k < 2 * WORD_CYC) begin
      @(negedge clk);
      k++;
    end
    chk("pop_edge_found", 32'(cyc == c0 + WORD_CYC), 32'd1);
    chk("pop_full_before", 32'(uart_tx_full), 32'd1);
    bus_if.write      = 1'b1;
    bus_if.write_data = $urandom;
    @(negedge clk);
    bus_if.write = 1'b0;
    chk("pop_write_dropped", 32'(bus_if.write_response), 32'd0);
    chk("pop_full_after", 32'(uart_tx_full), 32'd0);
    wait_rx(36, 9 * WORD_CYC + 200);
    check_bytes("full_byte");
    wait_idle(200);
    repeat (150) @(negedge clk);
    chk("full_no_extra", 32'(rx_q.size()), 32'd0);

    // reset during DATA of byte 2
    w_rst = $urandom;
    send_word(w_rst);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    k = 0;
    while (tx !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rst_word_started", 32'(tx), 32'd0);
    repeat (2 * FRAME + FRAME / 2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_empty", 32'(uart_tx_empty), 32'd1);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    repeat (FRAME + 50) @(negedge clk);
    chk("midrst_tx_idle", 32'(tx), 32'd1);
    check_bytes("midrst_partial");
    chk("midrst_no_resume", 32'(rx_q.size()), 32'd0);
    send_word(32'h00000001);
    wait_rx(4, WORD_CYC + 200);
    check_bytes("post_rst_byte");
    wait_idle(200);

`ifdef UART_TX_PARITY_EN
    // parity: 0x07 has odd weight, the zero bytes even
    repeat (20) @(negedge clk);
    send_word(32'h07000000);
    wait_rx(4, WORD_CYC + 200);
    chk("par_first_bit", 32'(rxp_q[0]), 32'd1);
    check_bytes("par_byte");
    wait_idle(200);
`endif

    repeat (50) @(negedge clk);
    chk("stop_bits", 32'(stop_err), 32'd0);
    chk("final_no_extra", 32'(rx_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
